// File: rtl/aes_uart_bridge_if.sv
// Byte-stream UART side and AES core side of the host bridge.
// master = bridge, slave = UART/core environment.
interface aes_uart_bridge_if;
    logic         rx_valid;
    logic [7:0]   rx_data;
    logic         tx_valid;
    logic [7:0]   tx_data;
    logic         tx_ready;
    logic         aes_reset;
    logic         aes_mode;
    logic [127:0] aes_data_in;
    logic [127:0] aes_key_in;
    logic [127:0] aes_data_out;
    logic         aes_done;

    modport master (
        input  rx_valid, rx_data, tx_ready, aes_data_out, aes_done,
        output tx_valid, tx_data, aes_reset, aes_mode, aes_data_in, aes_key_in
    );

    modport slave (
        output rx_valid, rx_data, tx_ready, aes_data_out, aes_done,
        input  tx_valid, tx_data, aes_reset, aes_mode, aes_data_in, aes_key_in
    );
endinterface

// File: rtl/aes_uart_bridge.sv
// Host-side bridge: UART command frame in, AES core sequencing,
// status byte plus 128b result out on the UART tx stream.
module aes_uart_bridge #(
    parameter int unsigned RX_GAP_CYCLES = 100000,
    parameter int unsigned RUN_TIMEOUT   = 255,
    parameter logic [7:0]  OK_CODE       = 8'hA5,
    parameter logic [7:0]  ERR_CODE      = 8'hEE
) (
    input  logic                clk,
    input  logic                reset,
    aes_uart_bridge_if.master   bus,
    output logic                busy,
    output logic                frame_err
);

    localparam int GW = (RX_GAP_CYCLES > 1) ? $clog2(RX_GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(RX_GAP_CYCLES - 1);
    localparam logic [15:0]   RUN_LAST = 16'(RUN_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX,
        ST_ARM,
        ST_RUN,
        ST_TX
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic           r_mode;
    logic [127:0]   r_data;
    logic [127:0]   r_key;
    logic [127:0]   r_result;
    logic [4:0]     r_byte_cnt;
    logic [GW-1:0]  r_gap_cnt;
    logic [15:0]    r_run_cnt;
    logic [4:0]     r_tx_left;
    logic           r_tx_valid;
    logic [7:0]     r_tx_data;
    logic           r_frame_err;
    logic           w_fe;
    logic           w_cmd_ok;
    logic           w_accept;
    logic           w_aes_reset;
    logic           w_busy;

    assign w_cmd_ok = (bus.rx_data[7:1] == 7'd0);
    assign w_accept = r_tx_valid && bus.tx_ready;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode plus state-derived outputs
    always_comb begin
        w_next      = r_state;
        w_fe        = 1'b0;
        w_aes_reset = 1'b1;
        w_busy      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.rx_valid) begin
                    if (w_cmd_ok) begin
                        w_next = ST_RX;
                    end else begin
                        w_fe = 1'b1;
                    end
                end
            end
            ST_RX: begin
                if (bus.rx_valid) begin
                    if (r_byte_cnt == 5'd31) begin
                        w_next = ST_ARM;
                    end
                end else if (r_gap_cnt == GAP_LAST) begin
                    w_fe   = 1'b1;
                    w_next = ST_IDLE;
                end
            end
            ST_ARM: begin
                w_busy = 1'b1;
                w_next = ST_RUN;
            end
            ST_RUN: begin
                w_busy      = 1'b1;
                w_aes_reset = 1'b0;
                if (bus.aes_done || r_run_cnt == RUN_LAST) begin
                    w_next = ST_TX;
                end
            end
            ST_TX: begin
                w_busy = 1'b1;
                if (w_accept && r_tx_left == 5'd0) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Frame assembly, core run timing and result serialisation
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mode      <= 1'b0;
            r_data      <= '0;
            r_key       <= '0;
            r_result    <= '0;
            r_byte_cnt  <= '0;
            r_gap_cnt   <= '0;
            r_run_cnt   <= '0;
            r_tx_left   <= '0;
            r_tx_valid  <= 1'b0;
            r_tx_data   <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_fe;
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.rx_valid && w_cmd_ok) begin
                        r_mode     <= bus.rx_data[0];
                        r_byte_cnt <= '0;
                        r_gap_cnt  <= '0;
                    end
                end
                ST_RX: begin
                    if (bus.rx_valid) begin
                        {r_data, r_key} <= {r_data[119:0], r_key, bus.rx_data};
                        r_byte_cnt      <= r_byte_cnt + 5'd1;
                        r_gap_cnt       <= '0;
                    end else if (r_gap_cnt == GAP_LAST) begin
                        r_data    <= '0;
                        r_key     <= '0;
                        r_gap_cnt <= '0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                ST_ARM: begin
                    r_run_cnt <= '0;
                end
                ST_RUN: begin
                    if (bus.aes_done) begin
                        r_result   <= bus.aes_data_out;
                        r_tx_data  <= OK_CODE;
                        r_tx_valid <= 1'b1;
                        r_tx_left  <= 5'd16;
                    end else if (r_run_cnt == RUN_LAST) begin
                        r_tx_data  <= ERR_CODE;
                        r_tx_valid <= 1'b1;
                        r_tx_left  <= 5'd0;
                    end else begin
                        r_run_cnt <= r_run_cnt + 16'd1;
                    end
                end
                ST_TX: begin
                    if (w_accept) begin
                        if (r_tx_left == 5'd0) begin
                            r_tx_valid <= 1'b0;
                        end else begin
                            r_tx_data <= r_result[127:120];
                            r_result  <= {r_result[119:0], 8'h00};
                            r_tx_left <= r_tx_left - 5'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.tx_valid    = r_tx_valid;
    assign bus.tx_data     = r_tx_data;
    assign bus.aes_reset   = w_aes_reset;
    assign bus.aes_mode    = r_mode;
    assign bus.aes_data_in = r_data;
    assign bus.aes_key_in  = r_key;
    assign busy            = w_busy;
    assign frame_err       = r_frame_err;

endmodule

// File: tb/tb_aes_uart_bridge.sv
// Directed bench for aes_uart_bridge with a behavioural AES core
// stand-in that answers the FIPS-197 C.1 vectors after a fixed latency.
module tb_aes_uart_bridge;

    localparam int GAP = 64;
    localparam int TMO = 255;
    localparam int LAT = 55;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic busy;
    logic frame_err;

    always #5 clk = ~clk;

    aes_uart_bridge_if bif();

    aes_uart_bridge #(
        .RX_GAP_CYCLES(GAP),
        .RUN_TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bif),
        .busy(busy),
        .frame_err(frame_err)
    );

    // Core stand-in
    int   m_cnt = 0;
    logic m_never = 1'b0;

    always @(posedge clk) begin
        if (bif.aes_reset) m_cnt <= 0;
        else if (m_cnt != LAT) m_cnt <= m_cnt + 1;
    end

    assign bif.aes_done = !m_never && !bif.aes_reset && (m_cnt == LAT);

    always_comb begin
        bif.aes_data_out = ~bif.aes_data_in;
        if (!bif.aes_mode && bif.aes_data_in == PT && bif.aes_key_in == KEY)
            bif.aes_data_out = CT;
        else if (bif.aes_mode && bif.aes_data_in == CT && bif.aes_key_in == KEY)
            bif.aes_data_out = PT;
    end

    int fe_cnt = 0;
    always @(negedge clk) if (frame_err) fe_cnt++;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        bif.rx_valid = 1'b1;
        bif.rx_data  = b;
        @(posedge clk); #1;
        bif.rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic m, input logic [127:0] d,
                              input logic [127:0] k);
        send_byte({7'd0, m});
        for (int i = 15; i >= 0; i--) send_byte(d[i*8 +: 8]);
        for (int i = 15; i >= 0; i--) send_byte(k[i*8 +: 8]);
    endtask

    logic [7:0] got_b [32];
    int got_n;
    int got_lat;
    int hold_bad;
    int stalled;

    // Accept bytes with tx_ready high, optionally stalling on byte stall_at
    task automatic collect(input int stall_at, input int stall_len);
        logic [7:0] held;
        held     = 8'h00;
        got_n    = 0;
        got_lat  = 0;
        hold_bad = 0;
        stalled  = 0;
        got_b[0] = 8'h00;
        for (int c = 1; c <= 2000; c++) begin
            @(negedge clk);
            if (bif.tx_valid && got_lat == 0) got_lat = c;
            if (bif.tx_valid && got_n == stall_at && stalled < stall_len) begin
                if (stalled == 0) held = bif.tx_data;
                else if (bif.tx_data !== held) hold_bad++;
                bif.tx_ready = 1'b0;
                stalled++;
            end else begin
                bif.tx_ready = 1'b1;
            end
            if (bif.tx_valid && bif.tx_ready) begin
                if (got_n < 32) got_b[got_n] = bif.tx_data;
                got_n++;
            end
            if (got_n > 0 && !busy) break;
        end
        bif.tx_ready = 1'b1;
    endtask

    function automatic logic [127:0] got_result();
        logic [127:0] r;
        r = '0;
        for (int i = 1; i <= 16; i++) r = {r[119:0], got_b[i]};
        return r;
    endfunction

    typedef struct {
        logic         mode;
        logic [127:0] data;
        logic [127:0] key;
        logic         never;
        logic [7:0]   status;
        logic [127:0] result;
        int           nbytes;
        int           lat;
    } vec_t;

    vec_t vecs [4];

    task automatic run_vec(input int i);
        m_never = vecs[i].never;
        send_frame(vecs[i].mode, vecs[i].data, vecs[i].key);
        collect(-1, 0);
        chk($sformatf("v%0d_count", i), 128'(got_n), 128'(vecs[i].nbytes));
        chk($sformatf("v%0d_status", i), 128'(got_b[0]), 128'(vecs[i].status));
        if (vecs[i].nbytes == 17)
            chk($sformatf("v%0d_result", i), got_result(), vecs[i].result);
        chk($sformatf("v%0d_latency", i), 128'(got_lat), 128'(vecs[i].lat));
        chk($sformatf("v%0d_idle", i),
            128'({busy, bif.tx_valid, bif.aes_reset}), 128'(3'b001));
        m_never = 1'b0;
    endtask

    initial begin
        bif.rx_valid = 1'b0;
        bif.rx_data  = 8'h00;
        bif.tx_ready = 1'b1;

        vecs[0] = '{1'b0, PT, KEY,    1'b0, 8'hA5, CT,  17, LAT + 3};
        vecs[1] = '{1'b1, CT, KEY,    1'b0, 8'hA5, PT,  17, LAT + 3};
        vecs[2] = '{1'b0, PT, 128'd0, 1'b0, 8'hA5, ~PT, 17, LAT + 3};
        vecs[3] = '{1'b0, PT, KEY,    1'b1, 8'hEE, '0,  1,  TMO + 2};

        #2;
        chk("rst_ctrl",
            128'({bif.tx_valid, bif.aes_reset, busy, frame_err, bif.aes_mode}),
            128'(5'b01000));
        chk("rst_txdata", 128'(bif.tx_data), 128'h0);
        chk("rst_data", bif.aes_data_in, 128'h0);
        chk("rst_key", bif.aes_key_in, 128'h0);
        #20 reset = 1'b1;

        for (int i = 0; i < 4; i++) run_vec(i);

        // Bad command byte
        send_byte(8'h02);
        @(negedge clk);
        chk("bad_pulse", 128'({frame_err, busy, bif.aes_reset}), 128'(3'b101));
        @(negedge clk);
        chk("bad_clear", 128'({frame_err, busy, bif.tx_valid}), 128'(3'b000));
        run_vec(0);

        // Rx gap timeout
        send_byte(8'h00);
        for (int i = 0; i < 10; i++) send_byte(8'h5A);
        for (int k = 1; k <= GAP + 2; k++) begin
            @(negedge clk);
            if (k == GAP) chk("gap_early", 128'(frame_err), 128'(1'b0));
            if (k == GAP + 1) chk("gap_pulse", 128'(frame_err), 128'(1'b1));
            if (k == GAP + 2) chk("gap_clear", 128'({frame_err, busy}), 128'(2'b00));
        end
        run_vec(0);

        // Backpressure in the middle of the result
        send_frame(1'b0, PT, KEY);
        collect(5, 20);
        chk("bp_stalled", 128'(stalled), 128'(20));
        chk("bp_hold", 128'(hold_bad), 128'(0));
        chk("bp_count", 128'(got_n), 128'(17));
        chk("bp_status", 128'(got_b[0]), 128'(8'hA5));
        chk("bp_result", got_result(), CT);

        // Reset during TX
        send_frame(1'b1, CT, KEY);
        begin
            int acc;
            acc = 0;
            for (int c = 0; c < 500 && acc < 3; c++) begin
                @(negedge clk);
                if (bif.tx_valid && bif.tx_ready) acc++;
            end
            chk("rtx_reached", 128'(acc), 128'(3));
        end
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk("rtx_ctrl", 128'({bif.tx_valid, bif.aes_reset, busy}), 128'(3'b010));
        chk("rtx_txdata", 128'(bif.tx_data), 128'h0);
        chk("rtx_data", bif.aes_data_in, 128'h0);
        #20 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rtx_stay", 128'({bif.tx_valid, busy}), 128'(2'b00));
        run_vec(1);

        repeat (4) @(negedge clk);
        chk("fe_total", 128'(fe_cnt), 128'(2));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
